mem_arbiter: RTL and testbench

Sequencer and arbiter for the single byte-wide RAM port in the out-of-order RISC-V core. It serves two requesters: instruction fetch, which reads 32-bit words, and the load/store buffer, which issues LB/LH/LW/LBU/LHU/SB/SH/SW. Each access is split into 1–4 sequential byte transfers. For loads, the assembled bytes are sign- or zero-extended before return. The block sits between the lsb/ifetch units and the top-level RAM/IO bus, and replaces direct memory access by either unit.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter_load_ext.sv | 28 ++
 rtl/mem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial memory arbiter:
// FSM encoding, requester ownership, the load/store op codes and the access-length helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_READ  = 2'd1,
        MA_WRITE = 2'd2
    } ma_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [4:0] OP_LB  = 5'd0;
    localparam logic [4:0] OP_LH  = 5'd1;
    localparam logic [4:0] OP_LW  = 5'd2;
    localparam logic [4:0] OP_LBU = 5'd3;
    localparam logic [4:0] OP_LHU = 5'd4;
    localparam logic [4:0] OP_SB  = 5'd5;
    localparam logic [4:0] OP_SH  = 5'd6;
    localparam logic [4:0] OP_SW  = 5'd7;

    // Number of byte transfers minus one for a given op.
    function automatic logic [1:0] op_len_m1(input logic [4:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_len_m1 = 2'd0;
            OP_LH, OP_LHU, OP_SH: op_len_m1 = 2'd1;
            default:              op_len_m1 = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM bus signals of the memory arbiter.
// master = the arbiter itself, slave = the fetch/LSB units plus the RAM.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_is_load;
    logic [4:0]  ls_op;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_valid;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport master (
        input  if_req, if_addr, ls_req, ls_is_load, ls_op, ls_addr, ls_wdata, mem_din,
        output if_valid, if_data, ls_valid, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_is_load, ls_op, ls_addr, ls_wdata, mem_din,
        input  if_valid, if_data, ls_valid, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter_load_ext.sv
// Combinational load-result extension: sign/zero extends the assembled bytes
// according to the load op; word loads (and fetches) pass through unchanged.
module mem_arbiter_load_ext
    import mem_arbiter_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] ext
);
    logic signed [7:0]  raw_b;
    logic signed [15:0] raw_h;
    logic signed [31:0] sx_b;
    logic signed [31:0] sx_h;

    always_comb begin
        raw_b = raw[7:0];
        raw_h = raw[15:0];
        sx_b  = raw_b;
        sx_h  = raw_h;
        case (op)
            OP_LB:   ext = sx_b;
            OP_LH:   ext = sx_h;
            OP_LBU:  ext = {24'd0, raw[7:0]};
            OP_LHU:  ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the single byte-wide RAM port: LSB beats fetch, each access
// is split into 1-4 byte transfers, loads are assembled little-endian and extended.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] ADDR_IO = 32'h30000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          rollback,
    input  logic          io_buffer_full,
    mem_arbiter_if.master bus
);
    ma_state_e   state, state_nxt;
    owner_e      owner, owner_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [1:0]  len_m1, len_m1_nxt;
    logic        squash, squash_nxt;
    logic        skid_vld;
    logic [7:0]  skid;
    logic [31:0] addr, addr_nxt;
    logic [31:0] wdata, wdata_nxt;
    logic [31:0] rbuf, rbuf_nxt;
    logic [4:0]  op, op_nxt;

    logic [31:0] mem_a_q, mem_a_nxt;
    logic [7:0]  mem_dout_q, mem_dout_nxt;
    logic        mem_wr_q, mem_wr_nxt;
    logic        if_valid_q, if_valid_nxt;
    logic        ls_valid_q, ls_valid_nxt;
    logic [31:0] if_data_q, if_data_nxt;
    logic [31:0] ls_rdata_q, ls_rdata_nxt;

    logic [2:0]  len;
    logic [7:0]  rd_byte;
    logic [31:0] asm_word;
    logic [31:0] ext_word;
    logic        iss_en;
    logic [31:0] iss_base, iss_data, iss_addr, iss_shift;
    logic [2:0]  iss_cnt;

    assign len = {1'b0, len_m1} + 3'd1;

    // A byte that arrived while paused is parked in the skid so that resuming
    // does not pick up the byte of the address presented during the pause.
    assign rd_byte = skid_vld ? skid : bus.mem_din;

    always_comb begin
        asm_word = rbuf;
        case (cnt)
            3'd1:    asm_word[7:0]   = rd_byte;
            3'd2:    asm_word[15:8]  = rd_byte;
            3'd3:    asm_word[23:16] = rd_byte;
            3'd4:    asm_word[31:24] = rd_byte;
            default: asm_word = rbuf;
        endcase
    end

    mem_arbiter_load_ext u_load_ext (
        .op  (op),
        .raw (asm_word),
        .ext (ext_word)
    );

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        cnt_nxt      = cnt;
        len_m1_nxt   = len_m1;
        squash_nxt   = squash;
        addr_nxt     = addr;
        wdata_nxt    = wdata;
        rbuf_nxt     = rbuf;
        op_nxt       = op;
        mem_a_nxt    = mem_a_q;
        mem_dout_nxt = mem_dout_q;
        mem_wr_nxt   = 1'b0;
        if_valid_nxt = 1'b0;
        ls_valid_nxt = 1'b0;
        if_data_nxt  = if_data_q;
        ls_rdata_nxt = ls_rdata_q;
        iss_en       = 1'b0;
        iss_base     = addr;
        iss_cnt      = cnt;
        iss_data     = wdata;

        case (state)
            MA_IDLE: begin
                // Requests seen alongside a done pulse or a flush are not granted.
                if (!if_valid_q && !ls_valid_q && !rollback) begin
                    if (bus.ls_req) begin
                        owner_nxt  = OWN_LS;
                        addr_nxt   = bus.ls_addr;
                        op_nxt     = bus.ls_op;
                        wdata_nxt  = bus.ls_wdata;
                        len_m1_nxt = op_len_m1(bus.ls_op);
                        cnt_nxt    = 3'd0;
                        squash_nxt = 1'b0;
                        if (bus.ls_is_load) begin
                            state_nxt = MA_READ;
                            mem_a_nxt = bus.ls_addr;
                        end else begin
                            state_nxt = MA_WRITE;
                            iss_en    = 1'b1;
                            iss_base  = bus.ls_addr;
                            iss_cnt   = 3'd0;
                            iss_data  = bus.ls_wdata;
                        end
                    end else if (bus.if_req) begin
                        owner_nxt  = OWN_IF;
                        addr_nxt   = bus.if_addr;
                        op_nxt     = OP_LW;
                        len_m1_nxt = 2'd3;
                        cnt_nxt    = 3'd0;
                        squash_nxt = 1'b0;
                        state_nxt  = MA_READ;
                        mem_a_nxt  = bus.if_addr;
                    end
                end
            end
            MA_READ: begin
                if (rollback) begin
                    state_nxt = MA_IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    rbuf_nxt = asm_word;
                    if (cnt == len) begin
                        state_nxt = MA_IDLE;
                        cnt_nxt   = 3'd0;
                        if (owner == OWN_LS) begin
                            ls_valid_nxt = 1'b1;
                            ls_rdata_nxt = ext_word;
                        end else begin
                            if_valid_nxt = 1'b1;
                            if_data_nxt  = ext_word;
                        end
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                        if (cnt < {1'b0, len_m1})
                            mem_a_nxt = addr + 32'(cnt) + 32'd1;
                    end
                end
            end
            MA_WRITE: begin
                // A flush never truncates a store; it only hides its completion.
                if (rollback)
                    squash_nxt = 1'b1;
                if (cnt == len) begin
                    state_nxt    = MA_IDLE;
                    cnt_nxt      = 3'd0;
                    ls_valid_nxt = !(squash || rollback);
                end else begin
                    iss_en = 1'b1;
                end
            end
            default: begin
                state_nxt = MA_IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase

        iss_addr  = iss_base + 32'(iss_cnt);
        iss_shift = iss_data >> {iss_cnt[1:0], 3'b000};
        if (iss_en && !(io_buffer_full && iss_addr >= ADDR_IO)) begin
            mem_wr_nxt   = 1'b1;
            mem_a_nxt    = iss_addr;
            mem_dout_nxt = iss_shift[7:0];
            cnt_nxt      = iss_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MA_IDLE;
            owner      <= OWN_IF;
            cnt        <= 3'd0;
            len_m1     <= 2'd0;
            squash     <= 1'b0;
            skid_vld   <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else if (!rdy) begin
            mem_wr_q <= 1'b0;
            if (state == MA_READ && cnt != 3'd0 && !skid_vld)
                skid_vld <= 1'b1;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            cnt        <= cnt_nxt;
            len_m1     <= len_m1_nxt;
            squash     <= squash_nxt;
            skid_vld   <= 1'b0;
            mem_a_q    <= mem_a_nxt;
            mem_dout_q <= mem_dout_nxt;
            mem_wr_q   <= mem_wr_nxt;
            if_valid_q <= if_valid_nxt;
            ls_valid_q <= ls_valid_nxt;
            if_data_q  <= if_data_nxt;
            ls_rdata_q <= ls_rdata_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            addr  <= addr_nxt;
            op    <= op_nxt;
            wdata <= wdata_nxt;
            rbuf  <= rbuf_nxt;
        end else if (state == MA_READ && cnt != 3'd0 && !skid_vld) begin
            skid <= bus.mem_din;
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.if_valid = if_valid_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_valid = ls_valid_q;
    assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: small byte RAM model plus per-scenario tasks
// with hand-computed expected bus activity and results.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic rollback = 1'b0;
    logic io_buffer_full = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.ADDR_IO(32'h30000)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rollback       (rollback),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // RAM: one-cycle read latency, address folded to 4 KiB.
    logic [7:0] ram [0:4095];
    bit ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h00; ram[12'h102] <= 8'h00; ram[12'h103] <= 8'h93;
            ram[12'h200] <= 8'h80;
            ram[12'h400] <= 8'h11; ram[12'h401] <= 8'h22; ram[12'h402] <= 8'h33; ram[12'h403] <= 8'h44;
            ram[12'h500] <= 8'h34; ram[12'h501] <= 8'hF2;
            ram[12'hFFE] <= 8'h01; ram[12'hFFF] <= 8'h02; ram[12'h000] <= 8'h03; ram[12'h001] <= 8'h04;
            ram_loaded <= 1'b1;
        end else if (bus.mem_wr) begin
            ram[bus.mem_a[11:0]] <= bus.mem_dout;
        end
        bus.mem_din <= ram[bus.mem_a[11:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ls_start(input logic ld, input logic [4:0] op, input logic [31:0] a, input logic [31:0] d);
        bus.ls_req = 1'b1; bus.ls_is_load = ld; bus.ls_op = op; bus.ls_addr = a; bus.ls_wdata = d;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) tick();
        n_checks++; if (bus.mem_a !== 32'd0) $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); else n_pass++;
        n_checks++; if (bus.mem_dout !== 8'd0) $display("FAIL reset_mem_dout: got %h want 0", bus.mem_dout); else n_pass++;
        n_checks++; if (bus.mem_wr !== 1'b0) $display("FAIL reset_mem_wr: got %b want 0", bus.mem_wr); else n_pass++;
        n_checks++; if (bus.if_valid !== 1'b0 || bus.ls_valid !== 1'b0)
            $display("FAIL reset_valid: got if=%b ls=%b want 0 0", bus.if_valid, bus.ls_valid); else n_pass++;
        n_checks++; if (bus.if_data !== 32'd0 || bus.ls_rdata !== 32'd0)
            $display("FAIL reset_data: got if=%h ls=%h want 0 0", bus.if_data, bus.ls_rdata); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch(input logic [31:0] a, input logic [31:0] exp_word, input logic [31:0] exp_a3);
        bus.if_req = 1'b1; bus.if_addr = a;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                n_checks++; if (bus.mem_a !== a || bus.mem_wr !== 1'b0)
                    $display("FAIL fetch_first_addr: got %h wr=%b want %h wr=0", bus.mem_a, bus.mem_wr, a); else n_pass++;
            end
            if (k == 3) begin
                n_checks++; if (bus.mem_a !== exp_a3)
                    $display("FAIL fetch_addr3: got %h want %h", bus.mem_a, exp_a3); else n_pass++;
            end
            if (k == 5) begin
                n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL fetch_early_valid: got %b want 0", bus.if_valid); else n_pass++;
            end
            if (k == 6) begin
                n_checks++; if (bus.if_valid !== 1'b1 || bus.if_data !== exp_word)
                    $display("FAIL fetch_result: got v=%b %h want v=1 %h", bus.if_valid, bus.if_data, exp_word); else n_pass++;
                bus.if_req = 1'b0;
            end
            if (k == 7) begin
                n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL fetch_pulse_len: got %b want 0", bus.if_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_lb_lbu();
        logic [4:0]  ops  [2];
        logic [31:0] exps [2];
        ops[0] = OP_LB;  exps[0] = 32'hFFFFFF80;
        ops[1] = OP_LBU; exps[1] = 32'h00000080;
        for (int t = 0; t < 2; t++) begin
            ls_start(1'b1, ops[t], 32'h200, 32'h0);
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (k == 2) begin
                    n_checks++; if (bus.ls_valid !== 1'b0) $display("FAIL lb_early_valid[%0d]: got %b want 0", t, bus.ls_valid); else n_pass++;
                end
                if (k == 3) begin
                    n_checks++; if (bus.ls_valid !== 1'b1 || bus.ls_rdata !== exps[t])
                        $display("FAIL lb_result[%0d]: got v=%b %h want v=1 %h", t, bus.ls_valid, bus.ls_rdata, exps[t]); else n_pass++;
                    bus.ls_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        ls_start(1'b0, OP_SW, 32'h300, 32'hDEADBEEF);
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k <= 4) begin
                n_checks++;
                if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h300 + 32'(k - 1) || bus.mem_dout !== exp_b[k-1])
                    $display("FAIL sw_byte%0d: got wr=%b a=%h d=%h want wr=1 a=%h d=%h", k - 1, bus.mem_wr, bus.mem_a,
                             bus.mem_dout, 32'h300 + 32'(k - 1), exp_b[k-1]);
                else n_pass++;
            end
            if (k == 5) begin
                n_checks++; if (bus.ls_valid !== 1'b1 || bus.mem_wr !== 1'b0)
                    $display("FAIL sw_done: got v=%b wr=%b want v=1 wr=0", bus.ls_valid, bus.mem_wr); else n_pass++;
                bus.ls_req = 1'b0;
            end
            if (k == 7) begin
                n_checks++; if (bus.mem_a !== 32'h300 || bus.mem_wr !== 1'b0)
                    $display("FAIL fetch_after_sw_addr: got %h wr=%b want 300 wr=0", bus.mem_a, bus.mem_wr); else n_pass++;
            end
            if (k == 11) begin
                n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL fetch_after_sw_early: got %b want 0", bus.if_valid); else n_pass++;
            end
            if (k == 12) begin
                n_checks++; if (bus.if_valid !== 1'b1 || bus.if_data !== 32'hDEADBEEF)
                    $display("FAIL fetch_after_sw: got v=%b %h want v=1 deadbeef", bus.if_valid, bus.if_data); else n_pass++;
                bus.if_req = 1'b0;
            end
        end
    endtask

    task automatic test_io_stall();
        ls_start(1'b0, OP_SB, 32'h30000, 32'h000000A5);
        io_buffer_full = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 3) begin
                n_checks++; if (bus.mem_wr !== 1'b0) $display("FAIL io_stall_cycle%0d: got wr=%b want 0", k, bus.mem_wr); else n_pass++;
            end
            if (k == 3) io_buffer_full = 1'b0;
            if (k == 4) begin
                n_checks++;
                if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h30000 || bus.mem_dout !== 8'hA5 || bus.ls_valid !== 1'b0)
                    $display("FAIL io_write: got wr=%b a=%h d=%h v=%b want wr=1 a=30000 d=a5 v=0",
                             bus.mem_wr, bus.mem_a, bus.mem_dout, bus.ls_valid);
                else n_pass++;
            end
            if (k == 5) begin
                n_checks++; if (bus.ls_valid !== 1'b1) $display("FAIL io_done: got %b want 1", bus.ls_valid); else n_pass++;
                bus.ls_req = 1'b0;
            end
        end
    endtask

    task automatic test_rollback_read();
        int seen = 0;
        ls_start(1'b1, OP_LW, 32'h400, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.ls_valid === 1'b1) seen++;
            if (k == 3) begin rollback = 1'b1; bus.ls_req = 1'b0; end
            if (k == 4) begin rollback = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h100; end
            if (k == 5) begin
                n_checks++; if (bus.mem_a !== 32'h100) $display("FAIL rb_idle_next: got a=%h want 100", bus.mem_a); else n_pass++;
            end
            if (k == 10) begin
                n_checks++; if (bus.if_valid !== 1'b1 || bus.if_data !== 32'h93000013 || bus.ls_rdata !== 32'h80)
                    $display("FAIL rb_followup: got v=%b if=%h ls=%h want v=1 93000013 80", bus.if_valid, bus.if_data,
                             bus.ls_rdata); else n_pass++;
                bus.if_req = 1'b0;
            end
        end
        n_checks++; if (seen != 0) $display("FAIL rb_read_no_valid: got %0d pulses want 0", seen); else n_pass++;
        tick();
        // request coinciding with a flush in IDLE must be dropped
        seen = 0;
        ls_start(1'b1, OP_LB, 32'h200, 32'h0);
        rollback = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                rollback = 1'b0; bus.ls_req = 1'b0;
                n_checks++; if (bus.mem_a !== 32'h103) $display("FAIL rb_idle_grant: got a=%h want 103", bus.mem_a); else n_pass++;
            end
            if (bus.ls_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL rb_idle_no_valid: got %0d pulses want 0", seen); else n_pass++;
    endtask

    task automatic test_rollback_write();
        logic [7:0] exp_b [4];
        int seen = 0;
        exp_b[0] = 8'h0D; exp_b[1] = 8'hF0; exp_b[2] = 8'hFE; exp_b[3] = 8'hCA;
        ls_start(1'b0, OP_SW, 32'h310, 32'hCAFEF00D);
        io_buffer_full = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 4) begin
                n_checks++;
                if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h310 + 32'(k - 1) || bus.mem_dout !== exp_b[k-1])
                    $display("FAIL rb_sw_byte%0d: got wr=%b a=%h d=%h want wr=1 a=%h d=%h", k - 1, bus.mem_wr,
                             bus.mem_a, bus.mem_dout, 32'h310 + 32'(k - 1), exp_b[k-1]);
                else n_pass++;
            end
            if (k == 2) begin rollback = 1'b1; bus.ls_req = 1'b0; end
            if (k == 3) rollback = 1'b0;
            if (k >= 5 && bus.ls_valid === 1'b1) seen++;
        end
        io_buffer_full = 1'b0;
        n_checks++; if (seen != 0) $display("FAIL rb_sw_no_valid: got %0d pulses want 0", seen); else n_pass++;
    endtask

    task automatic test_rst_mid_read();
        int seen = 0;
        ls_start(1'b1, OP_LW, 32'h400, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) rst = 1'b1;
            if (k == 3) begin
                n_checks++;
                if (bus.mem_a !== 32'd0 || bus.mem_wr !== 1'b0 || bus.mem_dout !== 8'd0 || bus.if_data !== 32'd0 ||
                    bus.ls_rdata !== 32'd0 || bus.if_valid !== 1'b0 || bus.ls_valid !== 1'b0)
                    $display("FAIL rst_mid_read: got a=%h wr=%b d=%h if=%h ls=%h v=%b%b want all 0", bus.mem_a,
                             bus.mem_wr, bus.mem_dout, bus.if_data, bus.ls_rdata, bus.if_valid, bus.ls_valid);
                else n_pass++;
                rst = 1'b0; bus.ls_req = 1'b0;
            end
            if (k >= 4 && bus.ls_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL rst_no_valid: got %0d pulses want 0", seen); else n_pass++;
    endtask

    task automatic test_rdy_pause();
        int seen = 0;
        ls_start(1'b1, OP_LH, 32'h500, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 2) rdy = 1'b0;
            if (k == 4) rdy = 1'b1;
            if (k <= 5 && bus.ls_valid === 1'b1) seen++;
            if (k == 6) begin
                n_checks++; if (bus.ls_valid !== 1'b1 || bus.ls_rdata !== 32'hFFFFF234)
                    $display("FAIL lh_paused: got v=%b %h want v=1 fffff234", bus.ls_valid, bus.ls_rdata); else n_pass++;
                bus.ls_req = 1'b0;
            end
            if (k == 7) begin
                n_checks++; if (bus.ls_valid !== 1'b0) $display("FAIL lh_pulse_len: got %b want 0", bus.ls_valid); else n_pass++;
            end
        end
        n_checks++; if (seen != 0) $display("FAIL lh_paused_early: got %0d pulses want 0", seen); else n_pass++;
        // a pause while a byte is on the bus withdraws the write strobe
        ls_start(1'b0, OP_SB, 32'h320, 32'h0000005A);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                n_checks++; if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 8'h5A)
                    $display("FAIL sb_pause_first: got wr=%b d=%h want wr=1 d=5a", bus.mem_wr, bus.mem_dout); else n_pass++;
                rdy = 1'b0;
            end
            if (k == 2) begin
                n_checks++; if (bus.mem_wr !== 1'b0) $display("FAIL sb_pause_wr: got %b want 0", bus.mem_wr); else n_pass++;
                rdy = 1'b1;
            end
            if (k == 3) begin
                n_checks++; if (bus.ls_valid !== 1'b1) $display("FAIL sb_pause_done: got %b want 1", bus.ls_valid); else n_pass++;
                bus.ls_req = 1'b0;
            end
        end
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.ls_req = 1'b0; bus.ls_is_load = 1'b0; bus.ls_op = OP_LB; bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;
        test_reset();
        test_fetch(32'h100, 32'h93000013, 32'h102);
        tick();
        test_lb_lbu();
        test_fetch(32'hFFFFFFFE, 32'h04030201, 32'h0);
        tick();
        test_priority();
        tick();
        test_io_stall();
        tick();
        test_rollback_read();
        tick();
        test_rollback_write();
        tick();
        test_rst_mid_read();
        tick();
        test_rdy_pause();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
